// File: rtl/gates_pipe.sv
// rtl/gates_pipe.sv - pipelined eight-function bitwise gate block with element and reduce modes
module gates_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic             z_zero,
  output logic             z_ones,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] res_cnt,
  output logic             busy
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;

  localparam logic MODE_ELEM = 1'b0;

  // Per-bit function; NOT a and pass a ignore y.
  function automatic logic [WIDTH-1:0] bitfn(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       sel
  );
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_NAND: r = ~(x & y);
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_NOTA: r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc;
  logic             first;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] elem_res;
  logic [WIDTH-1:0] red_res;
  logic [WIDTH-1:0] new_res;
  logic             new_out;

  // Single output register: a new beat may enter whenever the slot is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // Result selection for the beat currently offered.
  always_comb begin
    elem_res = bitfn(a, b, op);
    red_res  = first ? a : bitfn(acc, a, op);
    new_res  = (mode == MODE_ELEM) ? elem_res : red_res;
    new_out  = accept && ((mode == MODE_ELEM) || in_last);
  end

  // Output register: load on a producing accept, drop valid once drained, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      z         <= '0;
      z_zero    <= 1'b0;
      z_ones    <= 1'b0;
      out_valid <= 1'b0;
    end else if (new_out) begin
      z         <= new_res;
      z_zero    <= (new_res == '0);
      z_ones    <= (&new_res);
      out_valid <= 1'b1;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-result counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (clr) begin
      res_cnt <= '0;
    end else if (deliver) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

  // Reduce packet tracking; an element beat closes any open packet.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc   <= '0;
      first <= 1'b1;
      busy  <= 1'b0;
    end else if (accept) begin
      if (mode == MODE_ELEM || in_last) begin
        first <= 1'b1;
        busy  <= 1'b0;
      end else begin
        acc   <= red_res;
        first <= 1'b0;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gates_pipe.sv
// tb/tb_gates_pipe.sv - randomized and directed self-checking bench for gates_pipe
module tb_gates_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       op;
  logic             mode, in_valid, in_last, in_ready;
  logic [WIDTH-1:0] z;
  logic             z_zero, z_ones, out_valid, out_ready;
  logic [CNT_W-1:0] res_cnt;
  logic             busy;

  gates_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .op(op), .mode(mode),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .z(z), .z_zero(z_zero), .z_ones(z_ones), .out_valid(out_valid),
    .out_ready(out_ready), .res_cnt(res_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [WIDTH-1:0] got[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
  } beat_t;

  beat_t            pkt[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_z = '0;
  int               m_cnt = 0;

  function automatic logic [WIDTH-1:0] mf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic [2:0] s);
    case (s)
      3'd0: return x & y;
      3'd1: return ~(x & y);
      3'd2: return x | y;
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  always @(posedge clk) begin
    logic rdy, acc, del;
    logic [WIDTH-1:0] r;
    if (clr) begin
      m_valid = 1'b0;
      m_z     = '0;
      m_cnt   = 0;
      pkt.delete();
    end else begin
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy;
      del = m_valid && out_ready;
      if (del) begin
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_valid = 1'b0;
      end
      if (acc) begin
        if (!mode) begin
          m_z     = mf(a, b, op);
          m_valid = 1'b1;
          pkt.delete();
        end else begin
          pkt.push_back('{op: op, a: a});
          if (in_last) begin
            r = pkt[0].a;
            for (int i = 1; i < pkt.size(); i++) r = mf(r, pkt[i].a, pkt[i].op);
            m_z     = r;
            m_valid = 1'b1;
            pkt.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("busy", busy, pkt.size() != 0);
      chk("res_cnt", res_cnt, m_cnt);
      if (m_valid) begin
        chk("z", z, m_z);
        chk("z_zero", z_zero, m_z == '0);
        chk("z_ones", z_ones, m_z == {WIDTH{1'b1}});
      end
    end
    if (out_valid && out_ready && !clr) got.push_back(z);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic [2:0] o, input logic [WIDTH-1:0] av,
                      input logic [WIDTH-1:0] bv, input logic last);
    in_valid = 1'b1; mode = m; op = o; a = av; b = bv; in_last = last;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  logic [WIDTH-1:0] sweep_exp [8];

  initial begin
    clr = 1'b1; in_valid = 1'b1; in_last = 1'b0; mode = 1'b0; op = 3'd0;
    a = 8'h5A; b = 8'hA5; out_ready = 1'b0;

    // Reset with in_valid high for two cycles
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_res_cnt", res_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {z_zero, z_ones}, 0);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk_en = 1'b1;
    tick();

    // Truth-table sweep
    sweep_exp = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    got.delete();
    for (int k = 0; k < 8; k++) beat(1'b0, 3'(k), 8'hF0, 8'hCC, 1'b0);
    idle(2);
    chk("sweep_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk($sformatf("sweep_z%0d", k), got[k], sweep_exp[k]);
    chk("sweep_res_cnt", res_cnt, 8);

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    beat(1'b0, 3'd4, 8'hFF, 8'h0F, 1'b0);
    tick(); tick();
    chk("bp_hold_z", z, 8'hF0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(); tick();
    idle(2);
    chk("bp_count", got.size(), 3);
    chk("bp_res_cnt", res_cnt, 11);

    // Reduce XOR packet
    got.delete();
    beat(1'b1, 3'd4, 8'h01, 8'h00, 1'b0);
    chk("rx_busy1", busy, 1);
    chk("rx_noout1", out_valid, 0);
    beat(1'b1, 3'd4, 8'h02, 8'h00, 1'b0);
    chk("rx_busy2", busy, 1);
    beat(1'b1, 3'd4, 8'h04, 8'h00, 1'b1);
    chk("rx_busy3", busy, 0);
    chk("rx_z", z, 8'h07);
    idle(1);
    chk("rx_count", got.size(), 1);
    beat(1'b1, 3'd1, 8'h00, 8'hFF, 1'b1);
    chk("single_z", z, 8'h00);
    chk("single_zero", z_zero, 1);
    idle(1);

    // clr mid-packet
    got.delete();
    beat(1'b1, 3'd2, 8'h11, 8'h00, 1'b0);
    beat(1'b1, 3'd2, 8'h22, 8'h00, 1'b0);
    do_clr();
    chk("mclr_busy", busy, 0);
    chk("mclr_valid", out_valid, 0);
    chk("mclr_count", got.size(), 0);
    beat(1'b1, 3'd0, 8'h0F, 8'h00, 1'b0);
    beat(1'b1, 3'd0, 8'h3C, 8'h00, 1'b1);
    chk("fresh_z", z, 8'h0C);
    idle(1);

    // Element beat during a packet
    beat(1'b1, 3'd4, 8'h55, 8'h00, 1'b0);
    beat(1'b0, 3'd0, 8'hFF, 8'hFF, 1'b0);
    chk("abort_z", z, 8'hFF);
    chk("abort_ones", z_ones, 1);
    chk("abort_busy", busy, 0);
    idle(1);

    // Counter wrap at CNT_W=4
    do_clr();
    for (int k = 0; k < 17; k++) beat(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
    idle(1);
    chk("wrap_res_cnt", res_cnt, 1);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      clr       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 9) < 6);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gates_pipe.md
Name: gates_pipe

Overview:
- Parametrised, pipelined successor to the two-input six-function gate block.
- Applies one of eight selectable bitwise functions to WIDTH-bit operands behind a valid/ready handshake.
- Element mode: one result per accepted beat.
- Reduce mode: folds a packet of beats into one result, emitted on the last beat.
- Sits between a stimulus/switch source and a display or downstream consumer.

Parameters:
- WIDTH, 8, operand and result width in bits (1..32).
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored in reduce mode).
- op  input  3  function select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 pass a.
- mode  input  1  0 element, 1 reduce.
- in_valid  input  1  a/b/op/mode/in_last valid.
- in_last  input  1  marks the final beat of a reduce packet.
- in_ready  output  1  block accepts a beat this cycle.
- z  output  WIDTH  result.
- z_zero  output  1  z == 0.
- z_ones  output  1  z == all ones.
- out_valid  output  1  z/z_zero/z_ones valid.
- out_ready  input  1  consumer accepts the result.
- res_cnt  output  CNT_W  number of results delivered, wraps modulo 2^CNT_W.
- busy  output  1  reduce packet in progress.

Behaviour:
- Reset: one clock; clr is a synchronous, active-high reset.
  - On a clk edge with clr=1: z=0, z_zero=0, z_ones=0, out_valid=0, res_cnt=0, busy=0, accumulator=0, first-beat flag=1.
  - clr overrides all other inputs, including mid-packet; a partial reduce packet is discarded.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Deliver = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready; single output register, no bubble).
  - out_valid, z and flags hold stable until Deliver.
  - in_valid may drop without Accept; no input is latched without Accept.
- Function f(x,y,op) is computed per bit; op 6/7 ignore y. Results are masked to WIDTH.
- Element mode (mode=0):
  - On Accept: z <= f(a,b,op) and out_valid <= 1.
  - Latency 1 cycle from Accept to out_valid.
  - Throughput 1 beat/cycle when out_ready stays high.
  - in_last is ignored.
- Reduce mode (mode=1): packet = consecutive accepted mode=1 beats ending with in_last=1. op is sampled per beat.
  - First beat (first-beat flag=1): acc <= a; busy <= 1; flag <= 0.
  - Later beats: acc <= f(acc, a, op).
  - Beat with in_last=1: the result r (a if the beat is also first, else f(acc,a,op)) goes to z; out_valid <= 1; busy <= 0; flag <= 1. acc is not required to hold r.
  - Beats without in_last produce no output; in_ready for them follows the same rule.
  - Single-beat packet (first and last): z = a, independent of op.
- Mode switch: an element beat accepted while busy=1 aborts the packet (busy<=0, flag<=1). The element beat itself is processed normally.
- Flags: z_zero and z_ones are registered together with z. For WIDTH=1, z=1 sets z_ones only.
- Counting: res_cnt increments by 1 on each Deliver and wraps from 2^CNT_W-1 to 0.
- Simultaneous Deliver and Accept in the same cycle: the new result replaces the old one; out_valid stays 1.

Test Plan:
- Reset and idle: assert clr for 2 cycles with in_valid=1 -> out_valid=0, z=0, res_cnt=0, busy=0, in_ready=1 after release.
- Truth-table sweep (WIDTH=8): a=8'hF0, b=8'hCC, out_ready=1, op 0..7 over 8 consecutive cycles -> z = C0, 3F, FC, 03, 3C, C3, 0F, F0 on cycles 1..8 after Accept; z_ones never set; res_cnt=8.
- Backpressure: out_ready=0 with 3 beats offered (op=4, a=8'hFF, b=8'h0F) -> first result 8'hF0 held, in_ready=0 and no further Accept. Then out_ready=1 -> remaining two results delivered back-to-back, res_cnt=3.
- Reduce XOR: mode=1, op=4, beats a=8'h01, 8'h02, 8'h04, in_last on the third -> exactly one output z=8'h07, busy high from beat 1 until the beat-3 edge. Single-beat packet a=8'h00 with op=1 -> z=8'h00, z_zero=1.
- Mid-packet events:
  - clr after 2 of 4 reduce beats -> no output; the next packet starts fresh.
  - Element beat (op=0, a=b=8'hFF) during busy -> z=8'hFF, z_ones=1, busy=0.
- Counter wrap with CNT_W=4: deliver 17 results -> res_cnt=1.
